// File: rtl/enigma_seq_ctrl.sv
// Sequencer between a host byte stream and the enigma core: configures the core,
// buffers host chars, issues letters one at a time and returns results with an odometer.
module enigma_seq_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned SET_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_start_i,
    input  logic        cfg_dec_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [7:0]  in_char_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_char_o,
    output logic        core_set_o,
    output logic        core_en_o,
    output logic        core_valid_o,
    output logic [7:0]  core_din_o,
    output logic        core_dec_o,
    input  logic        core_done_i,
    input  logic [7:0]  core_dout_i,
    output logic [4:0]  pos1_o,
    output logic [4:0]  pos2_o,
    output logic [4:0]  pos3_o,
    output logic [15:0] char_count_o,
    output logic        busy_o,
    output logic        timeout_err_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(SET_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle, StConfig, StReady, StIssue, StWait, StOutput, StError
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]     char_q, char_d;
    logic [7:0]     out_char_q, out_char_d;
    logic           dec_q, dec_d;
    logic [4:0]     pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
    logic [15:0]    count_q, count_d;
    logic           terr_q, terr_d;
    logic [SW-1:0]  set_cnt_q, set_cnt_d;
    logic [WW-1:0]  wait_cnt_q, wait_cnt_d;

    logic       fifo_empty, fifo_full, active, push, pop, flush, cfg_accept, is_letter;
    logic [7:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign is_letter  = (head >= 8'h41) && (head <= 8'h5A);
    assign active     = (state_q == StReady) || (state_q == StIssue) ||
                        (state_q == StWait)  || (state_q == StOutput);
    assign cfg_accept = cfg_start_i && ((state_q == StIdle) || (state_q == StError) ||
                                        ((state_q == StReady) && fifo_empty));

    assign in_ready_o    = active && !fifo_full;
    assign push          = in_valid_i && in_ready_o;
    assign out_valid_o   = (state_q == StOutput);
    assign out_char_o    = out_char_q;
    assign core_set_o    = (state_q == StConfig);
    assign core_en_o     = active;
    assign core_valid_o  = (state_q == StIssue);
    assign core_din_o    = char_q;
    assign core_dec_o    = dec_q;
    assign pos1_o        = pos1_q;
    assign pos2_o        = pos2_q;
    assign pos3_o        = pos3_q;
    assign char_count_o  = count_q;
    assign timeout_err_o = terr_q;
    assign busy_o        = ((state_q != StIdle) && (state_q != StReady)) || !fifo_empty;

    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        out_char_d = out_char_q;
        dec_d      = dec_q;
        pos1_d     = pos1_q;
        pos2_d     = pos2_q;
        pos3_d     = pos3_q;
        count_d    = count_q;
        terr_d     = terr_q;
        set_cnt_d  = set_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pop        = 1'b0;
        flush      = 1'b0;

        unique case (state_q)
            StIdle: ;
            StConfig: begin
                if (set_cnt_q == SW'(SET_CYCLES - 1)) begin
                    state_d = StReady;
                end else begin
                    set_cnt_d = set_cnt_q + 1'b1;
                end
            end
            StReady: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    char_d = head;
                    if (is_letter) begin
                        state_d = StIssue;
                    end else begin
                        out_char_d = head;
                        state_d    = StOutput;
                    end
                end
            end
            StIssue: begin
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                if (core_done_i) begin
                    out_char_d = core_dout_i;
                    count_d    = count_q + 16'd1;
                    state_d    = StOutput;
                    // Odometer: each wheel carries into the next on 25 -> 0.
                    if (pos1_q == 5'd25) begin
                        pos1_d = '0;
                        if (pos2_q == 5'd25) begin
                            pos2_d = '0;
                            pos3_d = (pos3_q == 5'd25) ? 5'd0 : pos3_q + 5'd1;
                        end else begin
                            pos2_d = pos2_q + 5'd1;
                        end
                    end else begin
                        pos1_d = pos1_q + 5'd1;
                    end
                end else if (wait_cnt_q == WW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = StError;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StOutput: begin
                if (out_ready_i) begin
                    state_d = StReady;
                end
            end
            StError: flush = 1'b1;
            default: state_d = StIdle;
        endcase

        // A push landing in the same cycle as an accepted config is discarded by the flush.
        if (cfg_accept) begin
            state_d   = StConfig;
            set_cnt_d = '0;
            dec_d     = cfg_dec_i;
            pos1_d    = '0;
            pos2_d    = '0;
            pos3_d    = '0;
            count_d   = '0;
            terr_d    = 1'b0;
            flush     = 1'b1;
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            char_q     <= '0;
            out_char_q <= '0;
            dec_q      <= 1'b0;
            pos1_q     <= '0;
            pos2_q     <= '0;
            pos3_q     <= '0;
            count_q    <= '0;
            terr_q     <= 1'b0;
            set_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            char_q     <= char_d;
            out_char_q <= out_char_d;
            dec_q      <= dec_d;
            pos1_q     <= pos1_d;
            pos2_q     <= pos2_d;
            pos3_q     <= pos3_d;
            count_q    <= count_d;
            terr_q     <= terr_d;
            set_cnt_q  <= set_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_char_i;
        end
    end

endmodule
